// File: rtl/exe_mem_skid_reg_if.sv
// EXE->MEM boundary bus: EXE-side handshake and payload, MEM-side head entry, status flags.
interface exe_mem_skid_reg_if #(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 4
);
   logic          flush;
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] alu_res;
   logic [3:0]    alu_sr;
   logic          s_upd;
   logic [DW-1:0] st_val;
   logic [RW-1:0] dest;
   logic          wb_en;
   logic          mem_r;
   logic          mem_w;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] res_o;
   logic [DW-1:0] st_val_o;
   logic [RW-1:0] dest_o;
   logic          wb_en_o;
   logic          mem_r_o;
   logic          mem_w_o;
   logic [3:0]    status;
   logic          c_flag;

   modport master (
      output flush, in_valid, alu_res, alu_sr, s_upd, st_val, dest, wb_en, mem_r, mem_w,
             out_ready,
      input  in_ready, out_valid, res_o, st_val_o, dest_o, wb_en_o, mem_r_o, mem_w_o,
             status, c_flag
   );

   modport slave (
      input  flush, in_valid, alu_res, alu_sr, s_upd, st_val, dest, wb_en, mem_r, mem_w,
             out_ready,
      output in_ready, out_valid, res_o, st_val_o, dest_o, wb_en_o, mem_r_o, mem_w_o,
             status, c_flag
   );
endinterface

// File: rtl/exe_mem_skid_reg.sv
// EXE->MEM pipeline register with a 2-entry skid buffer and the architectural {Z,C,N,V} status.
module exe_mem_skid_reg #(
   parameter int unsigned DW = 32,
   parameter int unsigned RW = 4
) (
   input  logic                clk,
   input  logic                rst_n,
   exe_mem_skid_reg_if.slave   bus
);

   logic          r_head_valid;
   logic [DW-1:0] r_head_res;
   logic [DW-1:0] r_head_st;
   logic [RW-1:0] r_head_dest;
   logic          r_head_wb;
   logic          r_head_mr;
   logic          r_head_mw;

   logic          r_skid_valid;
   logic [DW-1:0] r_skid_res;
   logic [DW-1:0] r_skid_st;
   logic [RW-1:0] r_skid_dest;
   logic          r_skid_wb;
   logic          r_skid_mr;
   logic          r_skid_mw;

   logic [3:0]    r_status;

   logic          w_fire_in;
   logic          w_fire_out;
   logic          w_head_load;

   // Ready depends only on the skid flop, so no ready path runs from MEM back to EXE.
   assign w_fire_in   = bus.in_valid & ~r_skid_valid;
   assign w_fire_out  = r_head_valid & bus.out_ready;
   assign w_head_load = ~r_head_valid | (w_fire_out & ~r_skid_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_head_valid <= 1'b0;
         r_head_res   <= '0;
         r_head_st    <= '0;
         r_head_dest  <= '0;
         r_head_wb    <= 1'b0;
         r_head_mr    <= 1'b0;
         r_head_mw    <= 1'b0;
         r_skid_valid <= 1'b0;
         r_skid_res   <= '0;
         r_skid_st    <= '0;
         r_skid_dest  <= '0;
         r_skid_wb    <= 1'b0;
         r_skid_mr    <= 1'b0;
         r_skid_mw    <= 1'b0;
      end else if (bus.flush) begin
         r_head_valid <= 1'b0;
         r_skid_valid <= 1'b0;
      end else if (w_head_load) begin
         r_head_valid <= w_fire_in;
         if (w_fire_in) begin
            r_head_res  <= bus.alu_res;
            r_head_st   <= bus.st_val;
            r_head_dest <= bus.dest;
            r_head_wb   <= bus.wb_en;
            r_head_mr   <= bus.mem_r;
            r_head_mw   <= bus.mem_w;
         end
      end else if (w_fire_out) begin
         // Skid is full here, so in_ready is low and no input competes with the promotion.
         r_head_valid <= 1'b1;
         r_head_res   <= r_skid_res;
         r_head_st    <= r_skid_st;
         r_head_dest  <= r_skid_dest;
         r_head_wb    <= r_skid_wb;
         r_head_mr    <= r_skid_mr;
         r_head_mw    <= r_skid_mw;
         r_skid_valid <= 1'b0;
      end else if (w_fire_in) begin
         r_skid_valid <= 1'b1;
         r_skid_res   <= bus.alu_res;
         r_skid_st    <= bus.st_val;
         r_skid_dest  <= bus.dest;
         r_skid_wb    <= bus.wb_en;
         r_skid_mr    <= bus.mem_r;
         r_skid_mw    <= bus.mem_w;
      end
   end

   // Flags commit at EXE acceptance so the next condition check is not delayed by MEM stalls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_status <= '0;
      end else if (w_fire_in && bus.s_upd && !bus.flush) begin
         r_status <= bus.alu_sr;
      end
   end

   assign bus.in_ready  = ~r_skid_valid;
   assign bus.out_valid = r_head_valid;
   assign bus.res_o     = r_head_res;
   assign bus.st_val_o  = r_head_st;
   assign bus.dest_o    = r_head_dest;
   assign bus.wb_en_o   = r_head_wb & r_head_valid;
   assign bus.mem_r_o   = r_head_mr & r_head_valid;
   assign bus.mem_w_o   = r_head_mw & r_head_valid;
   assign bus.status    = r_status;
   assign bus.c_flag    = r_status[2];

endmodule
